// File: rtl/load_store_buffer_pkg.sv
// Shared encodings for the load/store buffer: op codes, access sizes, FSM states,
// default sizing and the memory-mapped IO address window.
package load_store_buffer_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_SW  = 3'd3,
    OP_LBU = 3'd4,
    OP_LHU = 3'd5,
    OP_SB  = 3'd6,
    OP_SH  = 3'd7
  } lsb_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsb_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DRAIN
  } lsb_state_e;

  localparam int unsigned LSB_DEPTH_DEF = 8;
  localparam int unsigned TAG_W_DEF     = 4;

  // Upper address half that selects the IO window 0x0003_0000..0x0003_FFFF
  localparam logic [15:0] IO_WIN_HI = 16'h0003;

  function automatic logic is_store(input lsb_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic lsb_size_e op_size(input lsb_op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  // Store data is presented LSB-aligned with unused upper bytes zeroed
  function automatic logic [31:0] store_data(input lsb_op_e op, input logic [31:0] d);
    case (op)
      OP_SB:   return {24'd0, d[7:0]};
      OP_SH:   return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_store_buffer_load_align.sv
// lsb_load_align: extracts the addressed byte/half/word from LSB-aligned
// memory read data and sign- or zero-extends it according to the load op.
module lsb_load_align
  import load_store_buffer_pkg::*;
(
  input  lsb_op_e     i_op,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_value
);

  always_comb begin
    o_value = i_rdata;
    case (i_op)
      OP_LB:   o_value = {{24{i_rdata[7]}}, i_rdata[7:0]};
      OP_LH:   o_value = {{16{i_rdata[15]}}, i_rdata[15:0]};
      OP_LBU:  o_value = {24'd0, i_rdata[7:0]};
      OP_LHU:  o_value = {16'd0, i_rdata[15:0]};
      default: o_value = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order queue of memory ops with operand snooping and a
// single outstanding memory access. Define LSB_IO_ORDER_EN to make loads in the
// IO window wait until they are at rob_head.
module load_store_buffer
  import load_store_buffer_pkg::*;
#(
  parameter int unsigned LSB_DEPTH = LSB_DEPTH_DEF,
  parameter int unsigned TAG_W     = TAG_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             to_lsb,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] rob_tag,
  input  logic [31:0]      imm,
  input  logic [31:0]      v1,
  input  logic [31:0]      v2,
  input  logic             q1_rdy,
  input  logic             q2_rdy,
  input  logic [TAG_W-1:0] q1,
  input  logic [TAG_W-1:0] q2,
  output logic             lsb_full,
  input  logic             rs_to_rob,
  input  logic [TAG_W-1:0] rs_dest,
  input  logic [31:0]      rs_value,
  input  logic [TAG_W-1:0] rob_head,
  input  logic             clear_all,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [1:0]       mem_size,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata,
  output logic             lb_to_rob,
  output logic [TAG_W-1:0] lb_dest,
  output logic [31:0]      lb_value,
  output logic             sb_to_rob,
  output logic [TAG_W-1:0] sb_dest
);

  localparam int unsigned PTR_W = $clog2(LSB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LSB_DEPTH);

  logic             r_valid  [LSB_DEPTH];
  lsb_op_e          r_op     [LSB_DEPTH];
  logic [TAG_W-1:0] r_tag    [LSB_DEPTH];
  logic [31:0]      r_imm    [LSB_DEPTH];
  logic [31:0]      r_v1     [LSB_DEPTH];
  logic [31:0]      r_v2     [LSB_DEPTH];
  logic             r_q1_rdy [LSB_DEPTH];
  logic             r_q2_rdy [LSB_DEPTH];
  logic [TAG_W-1:0] r_q1     [LSB_DEPTH];
  logic [TAG_W-1:0] r_q2     [LSB_DEPTH];

  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;

  lsb_state_e       r_state, w_state_nxt;
  lsb_op_e          r_cur_op;
  logic [TAG_W-1:0] r_cur_tag;
  logic             r_cur_in_q;

  logic             r_mem_we;
  logic [31:0]      r_mem_addr, r_mem_wdata;
  lsb_size_e        r_mem_size;
  logic             r_lb_to_rob, r_sb_to_rob;
  logic [TAG_W-1:0] r_lb_dest, r_sb_dest;
  logic [31:0]      r_lb_value;

  logic             w_issue, w_pop, w_start, w_can_start, w_done_busy, w_load_ok;
  logic [31:0]      w_iss_v1, w_iss_v2, w_h_v1, w_h_v2, w_h_addr, w_load_value;
  logic             w_iss_q1_rdy, w_iss_q2_rdy, w_h_b_rdy, w_h_d_rdy, w_h_store;

  // Either broadcast bus resolves a waiting operand; the ALU bus wins a tie
  function automatic logic bc_hit(input logic [TAG_W-1:0] q);
    return (rs_to_rob && (rs_dest == q)) || (r_lb_to_rob && (r_lb_dest == q));
  endfunction

  function automatic logic [31:0] bc_val(input logic [TAG_W-1:0] q);
    return (rs_to_rob && (rs_dest == q)) ? rs_value : r_lb_value;
  endfunction

  assign lsb_full    = (r_count == FULL_CNT);
  assign w_issue     = to_lsb && !lsb_full && !clear_all;
  assign w_done_busy = (r_state == ST_BUSY) && mem_done;
  assign w_pop       = w_done_busy && r_cur_in_q && !clear_all;

  always_comb begin
    w_iss_v1     = v1;
    w_iss_q1_rdy = q1_rdy;
    if (!q1_rdy && bc_hit(q1)) begin
      w_iss_v1     = bc_val(q1);
      w_iss_q1_rdy = 1'b1;
    end
    w_iss_v2     = v2;
    w_iss_q2_rdy = q2_rdy;
    if (!q2_rdy && bc_hit(q2)) begin
      w_iss_v2     = bc_val(q2);
      w_iss_q2_rdy = 1'b1;
    end
  end

  // Head operands see this cycle's broadcasts so a wake-up can start the access at once
  always_comb begin
    w_h_v1    = r_v1[r_head];
    w_h_b_rdy = r_q1_rdy[r_head];
    if (!r_q1_rdy[r_head] && bc_hit(r_q1[r_head])) begin
      w_h_v1    = bc_val(r_q1[r_head]);
      w_h_b_rdy = 1'b1;
    end
    w_h_v2    = r_v2[r_head];
    w_h_d_rdy = r_q2_rdy[r_head];
    if (!r_q2_rdy[r_head] && bc_hit(r_q2[r_head])) begin
      w_h_v2    = bc_val(r_q2[r_head]);
      w_h_d_rdy = 1'b1;
    end
    w_h_addr  = w_h_v1 + r_imm[r_head];
    w_h_store = is_store(r_op[r_head]);
  end

  always_comb begin
`ifdef LSB_IO_ORDER_EN
    w_load_ok = (w_h_addr[31:16] != IO_WIN_HI) || (r_tag[r_head] == rob_head);
`else
    w_load_ok = 1'b1;
`endif
    w_can_start = r_valid[r_head] && w_h_b_rdy && !clear_all &&
                  (w_h_store ? (w_h_d_rdy && (r_tag[r_head] == rob_head)) : w_load_ok);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_can_start) begin
          w_start     = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_done)
          w_state_nxt = ST_IDLE;
        else if (clear_all && !is_store(r_cur_op))
          w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (mem_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < LSB_DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_op[i]     <= OP_LB;
        r_tag[i]    <= '0;
        r_imm[i]    <= '0;
        r_v1[i]     <= '0;
        r_v2[i]     <= '0;
        r_q1_rdy[i] <= 1'b0;
        r_q2_rdy[i] <= 1'b0;
        r_q1[i]     <= '0;
        r_q2[i]     <= '0;
      end
    end else if (rdy_in) begin
      for (int unsigned i = 0; i < LSB_DEPTH; i++) begin
        if (r_valid[i] && !r_q1_rdy[i] && bc_hit(r_q1[i])) begin
          r_v1[i]     <= bc_val(r_q1[i]);
          r_q1_rdy[i] <= 1'b1;
        end
        if (r_valid[i] && !r_q2_rdy[i] && bc_hit(r_q2[i])) begin
          r_v2[i]     <= bc_val(r_q2[i]);
          r_q2_rdy[i] <= 1'b1;
        end
      end
      if (w_issue) begin
        r_valid[r_tail]  <= 1'b1;
        r_op[r_tail]     <= lsb_op_e'(op);
        r_tag[r_tail]    <= rob_tag;
        r_imm[r_tail]    <= imm;
        r_v1[r_tail]     <= w_iss_v1;
        r_v2[r_tail]     <= w_iss_v2;
        r_q1_rdy[r_tail] <= w_iss_q1_rdy;
        r_q2_rdy[r_tail] <= w_iss_q2_rdy;
        r_q1[r_tail]     <= q1;
        r_q2[r_tail]     <= q2;
        r_tail           <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_issue) - CNT_W'(w_pop);
      if (clear_all) begin
        for (int unsigned i = 0; i < LSB_DEPTH; i++) r_valid[i] <= 1'b0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end
    end
  end

  lsb_load_align u_load_align (
    .i_op    (r_cur_op),
    .i_rdata (mem_rdata),
    .o_value (w_load_value)
  );

  // r_cur_in_q drops on a flush so a surviving store does not pop a newer entry
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= ST_IDLE;
      r_cur_op    <= OP_LB;
      r_cur_tag   <= '0;
      r_cur_in_q  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_size  <= SZ_BYTE;
      r_lb_to_rob <= 1'b0;
      r_sb_to_rob <= 1'b0;
      r_lb_dest   <= '0;
      r_sb_dest   <= '0;
      r_lb_value  <= '0;
    end else if (rdy_in) begin
      r_state     <= w_state_nxt;
      r_lb_to_rob <= w_done_busy && !is_store(r_cur_op) && !clear_all;
      r_sb_to_rob <= w_done_busy && is_store(r_cur_op);
      if (w_done_busy && !is_store(r_cur_op) && !clear_all) begin
        r_lb_dest  <= r_cur_tag;
        r_lb_value <= w_load_value;
      end
      if (w_done_busy && is_store(r_cur_op)) r_sb_dest <= r_cur_tag;
      if (w_start) begin
        r_cur_op    <= r_op[r_head];
        r_cur_tag   <= r_tag[r_head];
        r_cur_in_q  <= 1'b1;
        r_mem_we    <= w_h_store;
        r_mem_addr  <= w_h_addr;
        r_mem_wdata <= store_data(r_op[r_head], w_h_v2);
        r_mem_size  <= op_size(r_op[r_head]);
      end else if (clear_all || w_done_busy) begin
        r_cur_in_q <= 1'b0;
      end
    end
  end

  assign mem_req   = (r_state != ST_IDLE);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_size  = r_mem_size;
  assign lb_to_rob = r_lb_to_rob;
  assign lb_dest   = r_lb_dest;
  assign lb_value  = r_lb_value;
  assign sb_to_rob = r_sb_to_rob;
  assign sb_dest   = r_sb_dest;

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer: table of load vectors plus hand-written
// sequences for store ordering, snooping, full/wrap and flush behaviour.
module tb_load_store_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        to_lsb = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [3:0]  rob_tag = 4'd0;
  logic [31:0] imm = 32'd0, v1 = 32'd0, v2 = 32'd0;
  logic        q1_rdy = 1'b1, q2_rdy = 1'b1;
  logic [3:0]  q1 = 4'd0, q2 = 4'd0;
  logic        lsb_full;
  logic        rs_to_rob = 1'b0;
  logic [3:0]  rs_dest = 4'd0;
  logic [31:0] rs_value = 32'd0;
  logic [3:0]  rob_head = 4'd0;
  logic        clear_all = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_done = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        lb_to_rob, sb_to_rob;
  logic [3:0]  lb_dest, sb_dest;
  logic [31:0] lb_value;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  load_store_buffer #(.LSB_DEPTH(8), .TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .to_lsb(to_lsb), .op(op),
    .rob_tag(rob_tag), .imm(imm), .v1(v1), .v2(v2), .q1_rdy(q1_rdy), .q2_rdy(q2_rdy),
    .q1(q1), .q2(q2), .lsb_full(lsb_full), .rs_to_rob(rs_to_rob), .rs_dest(rs_dest),
    .rs_value(rs_value), .rob_head(rob_head), .clear_all(clear_all), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .lb_to_rob(lb_to_rob), .lb_dest(lb_dest),
    .lb_value(lb_value), .sb_to_rob(sb_to_rob), .sb_dest(sb_dest)
  );

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [31:0] v1;
    logic [31:0] imm;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [1:0]  exp_size;
    logic [31:0] exp_value;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [3:0] t, input logic [31:0] im,
                       input logic [31:0] b, input logic [31:0] d,
                       input logic q1r, input logic [3:0] q1t);
    to_lsb = 1'b1; op = o; rob_tag = t; imm = im; v1 = b; v2 = d;
    q1_rdy = q1r; q1 = q1t; q2_rdy = 1'b1; q2 = 4'd0;
    step();
    to_lsb = 1'b0; q1_rdy = 1'b1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    check(name, 32'(mem_req), 32'd1);
  endtask

  task automatic done_pulse(input logic [31:0] rd);
    mem_done = 1'b1; mem_rdata = rd;
    step();
    mem_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    //          op    tag    v1            imm           rdata         addr          sz    value
    vecs[0] = '{3'd2, 4'd1, 32'h0000_1000, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_1008, 2'd2, 32'hDEAD_BEEF};
    vecs[1] = '{3'd0, 4'd2, 32'h0000_2000, 32'h0000_0001, 32'h0000_0080, 32'h0000_2001, 2'd0, 32'hFFFF_FF80};
    vecs[2] = '{3'd4, 4'd3, 32'h0000_2000, 32'h0000_0001, 32'h0000_0080, 32'h0000_2001, 2'd0, 32'h0000_0080};
    vecs[3] = '{3'd1, 4'd4, 32'h0000_3000, 32'h0000_0002, 32'h0000_8001, 32'h0000_3002, 2'd1, 32'hFFFF_8001};
    vecs[4] = '{3'd5, 4'd5, 32'h0000_3000, 32'h0000_0002, 32'h1234_8001, 32'h0000_3002, 2'd1, 32'h0000_8001};
    vecs[5] = '{3'd0, 4'd6, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_FF7F, 32'h0000_0010, 2'd0, 32'h0000_007F};
    vecs[6] = '{3'd2, 4'd7, 32'hFFFF_FFFC, 32'h0000_0008, 32'h1234_5678, 32'h0000_0004, 2'd2, 32'h1234_5678};
    vecs[7] = '{3'd2, 4'd8, 32'h0000_0100, 32'hFFFF_FFF0, 32'h0BAD_F00D, 32'h0000_00F0, 2'd2, 32'h0BAD_F00D};
    vecs[8] = '{3'd2, 4'd9, 32'h0003_0000, 32'h0000_0004, 32'hA5A5_5A5A, 32'h0003_0004, 2'd2, 32'hA5A5_5A5A};

    // reset
    step();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_full", 32'(lsb_full), 32'd0);
    check("rst_lb_to_rob", 32'(lb_to_rob), 32'd0);
    check("rst_sb_to_rob", 32'(sb_to_rob), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_lb_value", lb_value, 32'd0);
    rst_in = 1'b1;
    step();

    // load vectors (rob_head=0 never matches their tags, so loads must not wait for it)
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].tag, vecs[i].imm, vecs[i].v1, 32'd0, 1'b1, 4'd0);
      wait_req($sformatf("v%0d_req", i));
      check($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_size", i), 32'(mem_size), 32'(vecs[i].exp_size));
      check($sformatf("v%0d_we", i), 32'(mem_we), 32'd0);
      done_pulse(vecs[i].rdata);
      check($sformatf("v%0d_lb_to_rob", i), 32'(lb_to_rob), 32'd1);
      check($sformatf("v%0d_lb_value", i), lb_value, vecs[i].exp_value);
      check($sformatf("v%0d_lb_dest", i), 32'(lb_dest), 32'(vecs[i].tag));
      check($sformatf("v%0d_req_drop", i), 32'(mem_req), 32'd0);
      step();
      check($sformatf("v%0d_lb_pulse", i), 32'(lb_to_rob), 32'd0);
    end

    // store waits for rob_head
    rob_head = 4'd4;
    issue(3'd3, 4'd5, 32'h4, 32'h4000, 32'hCAFE_BABE, 1'b1, 4'd0);
    step(); step(); step();
    check("sw_hold", 32'(mem_req), 32'd0);
    rob_head = 4'd5;
    step();
    check("sw_req", 32'(mem_req), 32'd1);
    check("sw_we", 32'(mem_we), 32'd1);
    check("sw_addr", mem_addr, 32'h4004);
    check("sw_wdata", mem_wdata, 32'hCAFE_BABE);
    check("sw_size", 32'(mem_size), 32'd2);
    done_pulse(32'd0);
    check("sw_sb_to_rob", 32'(sb_to_rob), 32'd1);
    check("sw_sb_dest", 32'(sb_dest), 32'd5);
    check("sw_no_lb", 32'(lb_to_rob), 32'd0);
    step();
    check("sw_sb_pulse", 32'(sb_to_rob), 32'd0);

    // byte store
    rob_head = 4'd6;
    issue(3'd6, 4'd6, 32'h3, 32'h10, 32'h1234_56AB, 1'b1, 4'd0);
    wait_req("sb_req");
    check("sb_addr", mem_addr, 32'h13);
    check("sb_size", 32'(mem_size), 32'd0);
    check("sb_wdata", mem_wdata, 32'h0000_00AB);
    done_pulse(32'd0);
    check("sb_sb_dest", 32'(sb_dest), 32'd6);
    rob_head = 4'd0;

    // base waits for ALU broadcast
    issue(3'd2, 4'd2, 32'h10, 32'hBAD0_0000, 32'd0, 1'b0, 4'd3);
    step(); step();
    check("snoop_hold", 32'(mem_req), 32'd0);
    rs_to_rob = 1'b1; rs_dest = 4'd3; rs_value = 32'h2000;
    step();
    rs_to_rob = 1'b0;
    check("snoop_req", 32'(mem_req), 32'd1);
    check("snoop_addr", mem_addr, 32'h2010);
    done_pulse(32'h11);
    check("snoop_val", lb_value, 32'h11);
    check("snoop_dest", 32'(lb_dest), 32'd2);

    // broadcast captured in the issue cycle
    rs_to_rob = 1'b1; rs_dest = 4'd7; rs_value = 32'h500;
    issue(3'd2, 4'd8, 32'h4, 32'hBAD0_0000, 32'd0, 1'b0, 4'd7);
    rs_to_rob = 1'b0;
    wait_req("isscap_req");
    check("isscap_addr", mem_addr, 32'h504);
    done_pulse(32'h0);

    // base produced by an earlier load's result broadcast
    issue(3'd2, 4'd9, 32'h0, 32'h40, 32'd0, 1'b1, 4'd0);
    issue(3'd2, 4'd10, 32'h8, 32'hBAD0_0000, 32'd0, 1'b0, 4'd9);
    wait_req("lbsnoop_req0");
    check("lbsnoop_addr0", mem_addr, 32'h40);
    done_pulse(32'h6000);
    wait_req("lbsnoop_req1");
    check("lbsnoop_addr1", mem_addr, 32'h6008);
    done_pulse(32'h0);
    step();

    // fill, ignored 9th issue, pop and tail wrap
    for (int k = 0; k < 8; k++) issue(3'd3, 4'd9, 32'(k * 4), 32'h8000, 32'(k), 1'b1, 4'd0);
    check("full_set", 32'(lsb_full), 32'd1);
    issue(3'd3, 4'd9, 32'h100, 32'h8000, 32'd0, 1'b1, 4'd0);
    check("full_hold", 32'(lsb_full), 32'd1);
    rob_head = 4'd9;
    wait_req("fill_req0");
    check("fill_addr0", mem_addr, 32'h8000);
    done_pulse(32'd0);
    check("fill_sb0", 32'(sb_to_rob), 32'd1);
    check("full_clr", 32'(lsb_full), 32'd0);
    issue(3'd3, 4'd9, 32'h200, 32'h8000, 32'd0, 1'b1, 4'd0);
    check("full_again", 32'(lsb_full), 32'd1);
    for (int k = 1; k < 8; k++) begin
      wait_req($sformatf("fill_req%0d", k));
      check($sformatf("fill_addr%0d", k), mem_addr, 32'h8000 + 32'(k * 4));
      done_pulse(32'd0);
    end
    wait_req("wrap_req");
    check("wrap_addr", mem_addr, 32'h8200);
    done_pulse(32'd0);
    step(); step(); step(); step(); step();
    check("fill_drained", 32'(mem_req), 32'd0);
    check("fill_empty", 32'(lsb_full), 32'd0);
    rob_head = 4'd0;

    // flush with a load in flight
    issue(3'd2, 4'd3, 32'h0, 32'h300, 32'd0, 1'b1, 4'd0);
    issue(3'd2, 4'd4, 32'h0, 32'h400, 32'd0, 1'b1, 4'd0);
    wait_req("flush_req");
    check("flush_addr", mem_addr, 32'h300);
    clear_all = 1'b1;
    step();
    clear_all = 1'b0;
    check("drain_req", 32'(mem_req), 32'd1);
    issue(3'd2, 4'd6, 32'h0, 32'h700, 32'd0, 1'b1, 4'd0);
    step();
    check("drain_hold", 32'(mem_req), 32'd1);
    check("drain_addr", mem_addr, 32'h300);
    done_pulse(32'h55);
    check("drain_no_lb", 32'(lb_to_rob), 32'd0);
    check("drain_req_drop", 32'(mem_req), 32'd0);
    wait_req("post_drain_req");
    check("post_drain_addr", mem_addr, 32'h700);
    done_pulse(32'h77);
    check("post_drain_lb", 32'(lb_to_rob), 32'd1);
    check("post_drain_dest", 32'(lb_dest), 32'd6);
    check("post_drain_val", lb_value, 32'h77);

    // flush with a store in flight: store still completes
    rob_head = 4'd11;
    issue(3'd3, 4'd11, 32'h0, 32'h900, 32'h1, 1'b1, 4'd0);
    wait_req("fst_req");
    clear_all = 1'b1;
    step();
    clear_all = 1'b0;
    check("fst_req_hold", 32'(mem_req), 32'd1);
    done_pulse(32'd0);
    check("fst_sb", 32'(sb_to_rob), 32'd1);
    check("fst_dest", 32'(sb_dest), 32'd11);
    step(); step(); step();
    check("fst_idle", 32'(mem_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
